// File: rtl/ahb_pattern_master_if.sv
// AHB-Lite bus bundle between the pattern master and its single SRAM slave.
// The master drives the address/control/write-data side; the slave answers with ready, response and read data.
interface ahb_pattern_master_if;
    logic        hsel;
    logic        hwrite;
    logic        hready;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, hwrite, hready, hsize, hburst, htrans, haddr, hwdata,
        input  hready_resp, hresp, hrdata
    );

    modport slave (
        input  hsel, hwrite, hready, hsize, hburst, htrans, haddr, hwdata,
        output hready_resp, hresp, hrdata
    );
endinterface

// File: rtl/ahb_pattern_master.sv
// Writes seed-derived pattern over NUM_BEATS words in INCR bursts, reads back and counts mismatches.
// Zero-wait pass takes 2*NUM_BEATS+4 cycles from start to done; hready_resp low freezes every bus output.
module ahb_pattern_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_BEATS = 16
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [31:0]                seed,
    ahb_pattern_master_if.master       bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [15:0]                err_cnt,
    output logic [31:0]                fail_addr
);

    localparam logic [1:0]  HT_IDLE   = 2'b00;
    localparam logic [1:0]  HT_NONSEQ = 2'b10;
    localparam logic [1:0]  HT_SEQ    = 2'b11;
    localparam logic [1:0]  RESP_ERR  = 2'b01;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_LAST,
        S_GAP,
        S_RD_ADDR,
        S_RD_LAST,
        S_DONE
    } state_t;

    state_t      state_q;
    logic        hsel_q;
    logic        hwrite_q;
    logic [1:0]  htrans_q;
    logic [31:0] haddr_q;
    logic [31:0] hwdata_q;
    logic [15:0] cnt_q;
    logic        dph_vld_q;
    logic        dph_write_q;
    logic [15:0] dph_idx_q;
    logic [31:0] seed_q;
    logic        wr_only_q;
    logic        abort_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] err_cnt_q;
    logic [31:0] fail_addr_q;

    logic [31:0] haddr_d;
    logic [15:0] cnt_d;
    logic        addr_acc;
    logic        dph_done;
    logic        err_first;
    logic        rd_mis;

    function automatic logic [31:0] pattern(input logic [31:0] s, input logic [15:0] i);
        return s ^ {i, ~i};
    endfunction

    assign haddr_d   = haddr_q + 32'd4;
    assign cnt_d     = cnt_q + 16'd1;
    assign addr_acc  = bus.hready_resp && htrans_q[1];
    assign dph_done  = bus.hready_resp && dph_vld_q;
    // First cycle of a two-cycle ERROR: the pending address must be withdrawn next cycle.
    assign err_first = dph_vld_q && !bus.hready_resp && (bus.hresp == RESP_ERR);
    assign rd_mis    = dph_done && !dph_write_q && (bus.hresp != RESP_ERR) &&
                       (bus.hrdata != pattern(seed_q, dph_idx_q));

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            hsel_q      <= 1'b0;
            hwrite_q    <= 1'b0;
            htrans_q    <= HT_IDLE;
            haddr_q     <= 32'd0;
            hwdata_q    <= 32'd0;
            cnt_q       <= 16'd0;
            dph_vld_q   <= 1'b0;
            dph_write_q <= 1'b0;
            dph_idx_q   <= 16'd0;
            seed_q      <= 32'd0;
            wr_only_q   <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 16'd0;
            fail_addr_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            if (dph_done) begin
                dph_vld_q <= 1'b0;
            end
            if (rd_mis) begin
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
                if (err_cnt_q == 16'd0) begin
                    fail_addr_q <= BASE_ADDR + {14'd0, dph_idx_q, 2'b00};
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seed_q      <= seed;
                        wr_only_q   <= (mode == 2'b01);
                        abort_q     <= 1'b0;
                        err_q       <= 1'b0;
                        err_cnt_q   <= 16'd0;
                        fail_addr_q <= 32'd0;
                        cnt_q       <= 16'd0;
                        haddr_q     <= BASE_ADDR;
                        htrans_q    <= HT_NONSEQ;
                        hsel_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        hwrite_q    <= (mode != 2'b10);
                        state_q     <= (mode == 2'b10) ? S_RD_ADDR : S_WR_ADDR;
                    end
                end

                S_WR_ADDR, S_RD_ADDR: begin
                    if (err_first) begin
                        htrans_q <= HT_IDLE;
                        err_q    <= 1'b1;
                        abort_q  <= 1'b1;
                        state_q  <= (state_q == S_WR_ADDR) ? S_WR_LAST : S_RD_LAST;
                    end else if (addr_acc) begin
                        dph_vld_q   <= 1'b1;
                        dph_write_q <= hwrite_q;
                        dph_idx_q   <= cnt_q;
                        if (hwrite_q) begin
                            hwdata_q <= pattern(seed_q, cnt_q);
                        end
                        if (cnt_q == LAST_IDX) begin
                            htrans_q <= HT_IDLE;
                            state_q  <= (state_q == S_WR_ADDR) ? S_WR_LAST : S_RD_LAST;
                        end else begin
                            cnt_q    <= cnt_d;
                            haddr_q  <= haddr_d;
                            // Bursts may not cross a 1 KB boundary, so restart with NONSEQ there.
                            htrans_q <= (haddr_d[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
                        end
                    end
                end

                S_WR_LAST, S_RD_LAST: begin
                    if (err_first) begin
                        err_q   <= 1'b1;
                        abort_q <= 1'b1;
                    end else if (dph_done) begin
                        if (abort_q || wr_only_q || (state_q == S_RD_LAST)) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            hsel_q   <= 1'b0;
                            htrans_q <= HT_IDLE;
                            hwrite_q <= 1'b0;
                        end else begin
                            state_q  <= S_GAP;
                            hwrite_q <= 1'b0;
                        end
                    end
                end

                S_GAP: begin
                    state_q  <= S_RD_ADDR;
                    cnt_q    <= 16'd0;
                    haddr_q  <= BASE_ADDR;
                    htrans_q <= HT_NONSEQ;
                    hwrite_q <= 1'b0;
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hsel   = hsel_q;
    assign bus.hwrite = hwrite_q;
    assign bus.hready = bus.hready_resp;
    assign bus.hsize  = 3'b010;
    assign bus.hburst = 3'b001;
    assign bus.htrans = htrans_q;
    assign bus.haddr  = haddr_q;
    assign bus.hwdata = hwdata_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_ahb_pattern_master.sv
// Drives two pattern masters (default geometry and a 1 KB-crossing region) against a behavioural SRAM slave.
module tb_ahb_pattern_master;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        hreset = 1'b1;
    logic        start  = 1'b0;
    logic        sel_b  = 1'b0;
    logic [1:0]  mode   = 2'b00;
    logic [31:0] seed   = 32'd0;
    logic        s_ready = 1'b1;
    logic [1:0]  s_resp  = 2'b00;
    logic [31:0] s_rdata = 32'd0;

    int total = 0;
    int bad   = 0;

    ahb_pattern_master_if bus_a ();
    ahb_pattern_master_if bus_b ();

    assign bus_a.hready_resp = s_ready;
    assign bus_a.hresp       = s_resp;
    assign bus_a.hrdata      = s_rdata;
    assign bus_b.hready_resp = s_ready;
    assign bus_b.hresp       = s_resp;
    assign bus_b.hrdata      = s_rdata;

    logic start_a, start_b;
    assign start_a = start & ~sel_b;
    assign start_b = start & sel_b;

    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [15:0] err_cnt_a, err_cnt_b;
    logic [31:0] fail_a, fail_b;

    ahb_pattern_master u_dut (
        .hclk(hclk), .hreset(hreset), .start(start_a), .mode(mode), .seed(seed),
        .bus(bus_a.master), .busy(busy_a), .done(done_a), .err(err_a),
        .err_cnt(err_cnt_a), .fail_addr(fail_a)
    );

    ahb_pattern_master #(.BASE_ADDR(32'h0000_03F8), .NUM_BEATS(8)) u_dut_b (
        .hclk(hclk), .hreset(hreset), .start(start_b), .mode(mode), .seed(seed),
        .bus(bus_b.master), .busy(busy_b), .done(done_b), .err(err_b),
        .err_cnt(err_cnt_b), .fail_addr(fail_b)
    );

    logic        m_hsel, m_hwrite, m_busy, m_done, m_err;
    logic [1:0]  m_htrans;
    logic [31:0] m_haddr, m_hwdata, m_fail;
    logic [15:0] m_err_cnt;
    assign m_hsel    = sel_b ? bus_b.hsel   : bus_a.hsel;
    assign m_hwrite  = sel_b ? bus_b.hwrite : bus_a.hwrite;
    assign m_htrans  = sel_b ? bus_b.htrans : bus_a.htrans;
    assign m_haddr   = sel_b ? bus_b.haddr  : bus_a.haddr;
    assign m_hwdata  = sel_b ? bus_b.hwdata : bus_a.hwdata;
    assign m_busy    = sel_b ? busy_b : busy_a;
    assign m_done    = sel_b ? done_b : done_a;
    assign m_err     = sel_b ? err_b : err_a;
    assign m_err_cnt = sel_b ? err_cnt_b : err_cnt_a;
    assign m_fail    = sel_b ? fail_b : fail_a;

    // Behavioural SRAM slave state
    logic [31:0] mem [0:4095];
    logic [34:0] acc_q [$];
    int          stall_pct = 0;
    logic        err_en    = 1'b0;
    logic [31:0] err_addr  = 32'd0;
    int          err_ph    = 0;
    logic        dp_vld = 1'b0, dp_write = 1'b0;
    logic [31:0] dp_addr = 32'd0;
    logic        p_ready = 1'b1, p_err1 = 1'b0, p_dpw = 1'b0, p_hwrite = 1'b0;
    logic [1:0]  p_htrans = 2'b00;
    logic [31:0] p_haddr = 32'd0, p_hwdata = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] s, input int i);
        logic [15:0] k;
        k = 16'(i);
        return s ^ {k, ~k};
    endfunction

    // Slave: the response set at the negedge of a cycle is what the master samples at the end of it.
    always @(negedge hclk) begin
        if (hreset) begin
            dp_vld  = 1'b0;
            s_ready = 1'b1;
            s_resp  = 2'b00;
            p_ready = 1'b1;
            p_err1  = 1'b0;
            p_dpw   = 1'b0;
        end else begin
            if (m_hsel) begin
                if (p_err1) begin
                    chk("err_idle", 64'(m_htrans), 64'd0);
                end else if (!p_ready && p_htrans != 2'b00) begin
                    chk("stall_addr", 64'(m_haddr), 64'(p_haddr));
                    chk("stall_ctrl", 64'({m_hwrite, m_htrans}), 64'({p_hwrite, p_htrans}));
                end
                if (!p_ready && p_dpw) chk("stall_wdata", 64'(m_hwdata), 64'(p_hwdata));
            end
            p_err1 = 1'b0;
            if (err_en && err_ph == 0 && dp_vld && dp_write && dp_addr == err_addr) begin
                err_ph = 1; s_ready = 1'b0; s_resp = 2'b01; p_err1 = 1'b1;
            end else if (err_ph == 1) begin
                err_ph = 2; s_ready = 1'b1; s_resp = 2'b01;
            end else begin
                s_resp  = 2'b00;
                s_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
            end
            s_rdata = (dp_vld && !dp_write) ? mem[dp_addr[13:2]] : $urandom;
            p_dpw = dp_vld && dp_write;
            if (s_ready) begin
                if (dp_vld && dp_write && s_resp == 2'b00) mem[dp_addr[13:2]] = m_hwdata;
                dp_vld   = m_hsel && m_htrans[1];
                dp_write = m_hwrite;
                dp_addr  = m_haddr;
                if (dp_vld) acc_q.push_back({m_hwrite, m_htrans, m_haddr});
            end
            p_ready  = s_ready;
            p_htrans = m_htrans;
            p_haddr  = m_haddr;
            p_hwrite = m_hwrite;
            p_hwdata = m_hwdata;
        end
    end

    task automatic run_pass(input logic [1:0] md, input logic [31:0] sd, output int lat);
        acc_q.delete();
        @(negedge hclk);
        mode = md; seed = sd; start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        lat = 1;
        chk("first_beat", 64'({m_hsel, m_busy, m_hwrite, m_htrans}),
            64'({1'b1, 1'b1, (md != 2'b10), 2'b10}));
        while (!m_done && lat < 2000) begin
            @(negedge hclk);
            lat++;
        end
        chk("done_seen", 64'(lat < 2000), 64'd1);
        @(negedge hclk);
        chk("done_pulse", 64'({m_done, m_busy, m_hsel, m_htrans}), 64'd0);
    endtask

    // Reference transfer list: every beat address in order, NONSEQ on beat 0 and at 1 KB boundaries.
    task automatic chk_seq(input logic [31:0] base, input int n, input logic [1:0] md);
        logic [34:0] exp_q [$];
        logic [31:0] a;
        for (int p = 0; p < 2; p++) begin
            if (p == 0 && md == 2'b10) continue;
            if (p == 1 && md == 2'b01) continue;
            for (int i = 0; i < n; i++) begin
                a = base + 32'(4 * i);
                exp_q.push_back({(p == 0), ((i == 0) || (a[9:0] == 10'd0)) ? 2'b10 : 2'b11, a});
            end
        end
        chk("seq_len", 64'(acc_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++)
            chk("seq_xfer", 64'(acc_q[k]), 64'(exp_q[k]));
    endtask

    task automatic chk_mem(input logic [31:0] base, input int n, input logic [31:0] sd);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            chk("mem_word", 64'(mem[a[13:2]]), 64'(pat(sd, i)));
        end
    endtask

    task automatic chk_result(input logic e, input logic [15:0] cnt, input logic [31:0] fa);
        chk("err", 64'(m_err), 64'(e));
        chk("err_cnt", 64'(m_err_cnt), 64'(cnt));
        chk("fail_addr", 64'(m_fail), 64'(fa));
    endtask

    initial begin
        int lat;
        int nreads;
        int w;
        logic [31:0] sd;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;

        // Reset values
        repeat (3) @(negedge hclk);
        chk("rst_bus", 64'({m_hsel, m_hwrite, m_htrans}), 64'd0);
        chk("rst_addr", 64'({m_haddr, m_hwdata}), 64'd0);
        chk("rst_stat", 64'({m_busy, m_done, m_err, m_err_cnt}), 64'd0);
        chk("rst_fail", 64'(m_fail), 64'd0);
        chk("rst_const", 64'({bus_a.hsize, bus_a.hburst, bus_a.hready}), 64'({3'b010, 3'b001, 1'b1}));
        hreset = 1'b0;

        // Zero-wait write + verify
        run_pass(2'b00, 32'hA5A5_0000, lat);
        chk("lat_m00", 64'(lat), 64'd36);
        chk_seq(32'd0, 16, 2'b00);
        chk_mem(32'd0, 16, 32'hA5A5_0000);
        chk_result(1'b0, 16'd0, 32'd0);

        // 30% random wait states
        stall_pct = 30;
        sd = $urandom;
        run_pass(2'b00, sd, lat);
        chk_seq(32'd0, 16, 2'b00);
        chk_mem(32'd0, 16, sd);
        chk_result(1'b0, 16'd0, 32'd0);
        stall_pct = 0;

        // Write only, corrupt word 5, verify only
        sd = $urandom;
        run_pass(2'b01, sd, lat);
        chk("lat_m01", 64'(lat), 64'd18);
        chk_seq(32'd0, 16, 2'b01);
        mem[5] = mem[5] ^ 32'h0000_0100;
        run_pass(2'b10, sd, lat);
        chk("lat_m10", 64'(lat), 64'd18);
        chk_seq(32'd0, 16, 2'b10);
        chk_result(1'b0, 16'd1, 32'h0000_0014);

        // Mode 11 behaves as write then verify
        sd = $urandom;
        run_pass(2'b11, sd, lat);
        chk("lat_m11", 64'(lat), 64'd36);
        chk_seq(32'd0, 16, 2'b00);
        chk_result(1'b0, 16'd0, 32'd0);

        // Region crossing the 1 KB boundary
        sel_b = 1'b1;
        sd = $urandom;
        run_pass(2'b00, sd, lat);
        chk("lat_b", 64'(lat), 64'd20);
        chk_seq(32'h0000_03F8, 8, 2'b00);
        chk_mem(32'h0000_03F8, 8, sd);
        chk_result(1'b0, 16'd0, 32'd0);
        sel_b = 1'b0;

        // ERROR response on write beat 3
        err_ph = 0; err_addr = 32'h0000_000C; err_en = 1'b1;
        run_pass(2'b00, $urandom, lat);
        chk("err_inject", 64'(err_ph), 64'd2);
        chk("lat_err", 64'(lat), 64'd7);
        chk("err_flag", 64'(m_err), 64'd1);
        chk("err_xfers", 64'(acc_q.size()), 64'd4);
        nreads = 0;
        foreach (acc_q[k]) if (!acc_q[k][34]) nreads++;
        chk("err_noread", 64'(nreads), 64'd0);
        err_en = 1'b0;

        // Reset during read beat 7
        @(negedge hclk);
        mode = 2'b00; seed = $urandom; start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        w = 0;
        while (!(m_htrans != 2'b00 && !m_hwrite && m_haddr == 32'h0000_001C) && w < 200) begin
            @(negedge hclk);
            w++;
        end
        chk("rd7_reached", 64'(w < 200), 64'd1);
        hreset = 1'b1;
        @(negedge hclk);
        chk("rst_mid", 64'({m_hsel, m_htrans, m_busy, m_done}), 64'd0);
        hreset = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            chk("rst_nodone", 64'({m_done, m_busy}), 64'd0);
        end
        sd = $urandom;
        run_pass(2'b00, sd, lat);
        chk("lat_after_rst", 64'(lat), 64'd36);
        chk_seq(32'd0, 16, 2'b00);
        chk_result(1'b0, 16'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_pattern_master.md
Name: ahb_pattern_master

Overview:
- AHB-Lite traffic master that sits directly upstream of sramc_top and drives its slave port.
- Writes a deterministic data pattern into a contiguous SRAM word region using INCR bursts, then reads the region back and compares it.
- Reports mismatches for bring-up, soak test and regression of the SRAM controller without a CPU.
- Single-slave fabric: drives hsel and the slave hready input directly.

Parameters:
- BASE_ADDR, 32'h0000_0000, word-aligned start address of the test region.
- NUM_BEATS, 16, number of 32-bit words per pass; legal range 1..1024.

Ports:
- hclk  in  1  system clock; all logic rising-edge.
- hreset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  00 write then read-verify; 01 write only; 10 read-verify only; 11 treated as 00.
- seed  in  32  pattern seed; captured on accepted start.
- hsel  out  1  slave select.
- hwrite  out  1  1 = write address phase.
- hready  out  1  slave hready input; equals hready_resp combinationally.
- hsize  out  3  constant 3'b010 (word).
- hburst  out  3  constant 3'b001 (INCR).
- htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- haddr  out  32  transfer address.
- hwdata  out  32  write data, valid in the data phase.
- hready_resp  in  1  slave ready.
- hresp  in  2  slave response; 2'b01 = ERROR.
- hrdata  in  32  read data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at pass end.
- err  out  1  sticky; set on hresp ERROR; cleared on next accepted start.
- err_cnt  out  16  read mismatch count; saturates at 16'hFFFF.
- fail_addr  out  32  address of first mismatch; 0 if none.

Behaviour:
- Reset values: all outputs 0 except hsize=3'b010, hburst=3'b001, hready=hready_resp; FSM to IDLE.
- Reset mid-operation abandons the pass in one cycle; no done pulse.
- Pattern for beat i (0..NUM_BEATS-1): P(i) = seed ^ {i[15:0], ~i[15:0]}. Address A(i) = BASE_ADDR + 4*i.
- FSM states: IDLE -> WR_ADDR -> WR_LAST -> GAP -> RD_ADDR -> RD_LAST -> DONE -> IDLE.
  - mode 01 goes WR_LAST -> DONE.
  - mode 10 goes IDLE -> RD_ADDR.
- start:
  - start in IDLE: the next cycle drives the first NONSEQ address; hsel=1 and busy=1 from that cycle.
  - start while busy is ignored.
- Address phase:
  - Beat 0 is NONSEQ; later beats are SEQ.
  - Any beat whose address has A[9:0]==0 and i>0 is NONSEQ (1 KB burst boundary rule).
  - An address is accepted on a rising edge with hready_resp=1; haddr, htrans and hwrite then advance.
- Data phase:
  - hwdata=P(i) is driven in the cycle after address i is accepted.
  - hwdata is held while hready_resp=0.
- WR_LAST/RD_LAST: htrans=IDLE while the final data phase completes.
- GAP: exactly one cycle with htrans=IDLE and hwrite=0 between the write and read passes.
- Read compare:
  - Performed when a read data phase completes (hready_resp=1).
  - On hrdata != P(i): err_cnt increments (saturating); the first mismatch latches fail_addr=A(i).
- Wait states: while hready_resp=0, haddr, htrans, hwrite and hwdata are all stable.
- Error response:
  - hresp=2'b01 with hready_resp=0 (first ERROR cycle): the next cycle drives htrans=IDLE and sets err.
  - On completion of the error response, the FSM goes to DONE.
  - Remaining beats are skipped.
- DONE: done=1 for one cycle; busy, hsel and htrans return to 0; counters hold until the next start.
- Zero-wait latency, mode 00: done is asserted exactly 2*NUM_BEATS+4 cycles after the start cycle.
  - Breakdown: N write addresses, 1 last-data cycle, 1 GAP, N read addresses, 1 last-data cycle, then done.
- NUM_BEATS=1: single NONSEQ write, then a single NONSEQ read; no SEQ issued.

Test Plan:
- Reset, then mode 00, seed 32'hA5A5_0000, NUM_BEATS 16, BASE 0, zero wait states -> htrans NONSEQ,SEQx15 on writes and reads; err_cnt=0; fail_addr=0; done at cycle 36.
- Random hready_resp=0 insertion (30%) during mode 00 -> haddr, htrans and hwdata stable across every stall; final err_cnt=0.
- Mode 01, then corrupt SRAM word 5 via backdoor, then mode 10 -> err_cnt=1; fail_addr=BASE+0x14.
- BASE_ADDR=32'h3F8, NUM_BEATS=8 -> beat 2 (addr 0x400) issued as NONSEQ; all others in the burst are SEQ.
- Force hresp=ERROR two-cycle response on write beat 3 -> htrans=IDLE in the second ERROR cycle; err=1; done pulses; no read transfers issued.
- Assert hreset during read beat 7 -> the next cycle has hsel=0, htrans=IDLE, busy=0 and no done; a subsequent start runs cleanly.
